// File: rtl/branch_pkg.sv
// Shared types and default sizes for the branch controller and its target LUT.
package branch_pkg;

   localparam int LUT_N = 16;
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      SHADOW = 2'd1,
      HALTED = 2'd2
   } bstate_t;

   typedef enum logic [1:0] {
      C_ALWAYS = 2'd0,
      C_Z      = 2'd1,
      C_NZ     = 2'd2,
      C_N      = 2'd3
   } cond_t;

endpackage

// File: rtl/branch_ctrl_target_lut.sv
// Branch target register file: synchronous write, asynchronous read, synchronous clear.
module target_lut #(
   parameter int W     = 16,
   parameter int LUT_N = 16,
   parameter int IW    = $clog2(LUT_N)
) (
   input  logic          clk,
   input  logic          init,
   input  logic          we,
   input  logic [IW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [IW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [LUT_N];

   always_ff @(posedge clk) begin
      if (init) begin
         for (int i = 0; i < LUT_N; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Reading the registers directly means a same-index write this cycle is not visible yet.
   assign rdata = mem[raddr];

endmodule

// File: rtl/branch_ctrl.sv
// Branch/loop/halt controller feeding the PC jump interface; one squash cycle follows each taken jump.
module branch_ctrl
   import branch_pkg::*;
#(
   parameter int W       = 16,
   parameter int LUT_N_P = branch_pkg::LUT_N,
   parameter int CNT_W_P = branch_pkg::CNT_W,
   parameter int IW      = $clog2(LUT_N_P)
) (
   input  logic               CLK,
   input  logic               Init,
   input  logic               is_cmp,
   input  logic               alu_z,
   input  logic               alu_n,
   input  logic               is_branch,
   input  logic [1:0]         cond,
   input  logic               is_loop,
   input  logic               cnt_load,
   input  logic [CNT_W_P-1:0] cnt_val,
   input  logic [IW-1:0]      lut_idx,
   input  logic               lut_we,
   input  logic [IW-1:0]      lut_waddr,
   input  logic [W-1:0]       lut_wdata,
   input  logic               halt_req,
   output logic               Branch_abs,
   output logic               B_TAKEN,
   output logic [W-1:0]       Target,
   output logic               squash,
   output logic               Halt,
   output bstate_t            state,
   output logic               flag_z,
   output logic               flag_n,
   output logic [CNT_W_P-1:0] loop_cnt
);

   bstate_t      state_q, state_d;
   logic         in_run;
   logic         cond_ok;
   logic         loop_ok;
   logic [W-1:0] lut_rdata;

   assign in_run = (state_q == RUN);

   target_lut #(.W(W), .LUT_N(LUT_N_P), .IW(IW)) u_lut (
      .clk   (CLK),
      .init  (Init),
      .we    (lut_we & in_run),
      .waddr (lut_waddr),
      .wdata (lut_wdata),
      .raddr (lut_idx),
      .rdata (lut_rdata)
   );

   // State register
   always_ff @(posedge CLK) begin
      if (Init) state_q <= RUN;
      else      state_q <= state_d;
   end

   always_ff @(posedge CLK) begin
      if (Init) begin
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else if (in_run && is_cmp) begin
         flag_z <= alu_z;
         flag_n <= alu_n;
      end
   end

   // Load beats decrement; decrement saturates at zero.
   always_ff @(posedge CLK) begin
      if (Init) begin
         loop_cnt <= '0;
      end else if (in_run) begin
         if (cnt_load)                     loop_cnt <= cnt_val;
         else if (is_loop && loop_cnt != 0) loop_cnt <= loop_cnt - CNT_W_P'(1);
      end
   end

   always_comb begin
      cond_ok = 1'b0;
      case (cond_t'(cond))
         C_ALWAYS: cond_ok = 1'b1;
         C_Z:      cond_ok = flag_z;
         C_NZ:     cond_ok = !flag_z;
         C_N:      cond_ok = flag_n;
         default:  cond_ok = 1'b0;
      endcase
   end

   assign loop_ok = (loop_cnt != CNT_W_P'(1)) && (loop_cnt != '0);

   // Output logic; is_loop wins over is_branch and halt suppresses the take.
   always_comb begin
      Branch_abs = 1'b0;
      B_TAKEN    = 1'b0;
      Target     = '0;
      if (!Init && in_run) begin
         Branch_abs = is_branch | is_loop;
         B_TAKEN    = (is_loop ? loop_ok : (is_branch & cond_ok)) & !halt_req;
         Target     = lut_rdata;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (halt_req)                  state_d = HALTED;
            else if (Branch_abs && B_TAKEN) state_d = SHADOW;
         end
         SHADOW:  state_d = RUN;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   assign squash = (state_q == SHADOW);
   assign Halt   = (state_q == HALTED);
   assign state  = state_q;

   illegal_branch_and_loop: assert property (@(posedge CLK) disable iff (Init)
      !(in_run && is_branch && is_loop));

endmodule
